// File: rtl/uop_store_pkg.sv
// Shared types and helpers for the microcode store.
package uop_store_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } uop_store_state_e;

  function automatic int bytes_per_uop(input int width);
    return (width + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/uop_store_packer.sv
// Byte-to-word assembly for the uop loader: little-endian packing, zero padding
// of a short final word and, with UOP_STORE_CHECKSUM_EN, the trailer XOR check.
module uop_store_packer
  import uop_store_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             byte_en,
  input  logic [7:0]       byte_in,
  input  logic             last_in,
  output logic             word_stb,
  output logic [WIDTH-1:0] word_out,
  output logic             last_stb,
  output logic             chk_err
);

  localparam int BPU  = bytes_per_uop(WIDTH);
  localparam int BW   = BPU * BYTE_W;
  localparam int CNTW = (BPU > 1) ? $clog2(BPU) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BPU - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  logic [CNTW-1:0] bcnt_q, bcnt_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [BW-1:0]   merged_s;
  logic            bcnt_full_s;

  // Current buffer with the incoming byte dropped into its lane.
  always_comb begin
    merged_s = buf_q;
    for (int k = 0; k < BPU; k++) begin
      if (bcnt_q == CNTW'(k)) begin
        merged_s[k*BYTE_W +: BYTE_W] = byte_in;
      end else begin
        merged_s[k*BYTE_W +: BYTE_W] = buf_q[k*BYTE_W +: BYTE_W];
      end
    end
  end

  assign bcnt_full_s = (bcnt_q == CNT_LAST);

`ifdef UOP_STORE_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;

  // Packing next-state; the trailer byte only flushes and checks, it is not data.
  always_comb begin
    bcnt_d   = bcnt_q;
    buf_d    = buf_q;
    xor_d    = xor_q;
    word_stb = 1'b0;
    word_out = merged_s[WIDTH-1:0];
    last_stb = 1'b0;
    chk_err  = 1'b0;
    if (clr) begin
      bcnt_d = '0;
      buf_d  = '0;
      xor_d  = 8'h00;
    end else if (byte_en) begin
      if (last_in) begin
        word_stb = (bcnt_q != '0);
        word_out = buf_q[WIDTH-1:0];
        last_stb = 1'b1;
        chk_err  = (xor_q != byte_in);
        bcnt_d   = '0;
        buf_d    = '0;
        xor_d    = 8'h00;
      end else begin
        xor_d = xor_q ^ byte_in;
        if (bcnt_full_s) begin
          word_stb = 1'b1;
          bcnt_d   = '0;
          buf_d    = '0;
        end else begin
          bcnt_d = bcnt_q + CNT_ONE;
          buf_d  = merged_s;
        end
      end
    end else begin
      bcnt_d = bcnt_q;
    end
  end

  // Packer state including the running checksum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt_q <= '0;
      buf_q  <= '0;
      xor_q  <= 8'h00;
    end else begin
      bcnt_q <= bcnt_d;
      buf_q  <= buf_d;
      xor_q  <= xor_d;
    end
  end
`else
  // Packing next-state; the final byte is data and closes a zero-padded word.
  always_comb begin
    bcnt_d   = bcnt_q;
    buf_d    = buf_q;
    word_stb = 1'b0;
    word_out = merged_s[WIDTH-1:0];
    last_stb = 1'b0;
    chk_err  = 1'b0;
    if (clr) begin
      bcnt_d = '0;
      buf_d  = '0;
    end else if (byte_en) begin
      last_stb = last_in;
      if (bcnt_full_s || last_in) begin
        word_stb = 1'b1;
        bcnt_d   = '0;
        buf_d    = '0;
      end else begin
        bcnt_d = bcnt_q + CNT_ONE;
        buf_d  = merged_s;
      end
    end else begin
      bcnt_d = bcnt_q;
    end
  end

  // Packer state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt_q <= '0;
      buf_q  <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      buf_q  <= buf_d;
    end
  end
`endif

endmodule

// File: rtl/uop_store.sv
// Microcode store: byte-serial loader fills the uop RAM, then fetches are served
// with one cycle of latency. Optional trailer checksum: UOP_STORE_CHECKSUM_EN.
module uop_store
  import uop_store_pkg::*;
#(
  parameter int UOP_BUF_SIZE  = 128,
  parameter int UOP_BUF_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [$clog2(UOP_BUF_SIZE)-1:0] uop_addr,
  output logic [UOP_BUF_WIDTH-1:0]        uop,
  output logic                            uop_valid,
  input  logic                            ld_valid,
  output logic                            ld_ready,
  input  logic [7:0]                      ld_byte,
  input  logic                            ld_last,
  input  logic                            ld_restart,
  output logic                            ld_done,
  output logic                            ld_err
);

  localparam int AW = $clog2(UOP_BUF_SIZE);
  localparam int CW = $clog2(UOP_BUF_SIZE + 1);
  localparam logic [CW-1:0] SIZE_C = CW'(UOP_BUF_SIZE);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  uop_store_state_e state_q, state_d;
  logic [CW-1:0]    waddr_q, waddr_d;
  logic [CW-1:0]    loaded_q, loaded_d;
  logic [UOP_BUF_WIDTH-1:0] uop_q, uop_d;
  logic             uop_valid_q, uop_valid_d;
  logic             ld_ready_q, ld_ready_d;
  logic             ld_done_q, ld_done_d;
  logic             ld_err_q, ld_err_d;
  logic             chk_bad_q, chk_bad_d;

  logic                     xfer_s;
  logic                     word_stb_s;
  logic [UOP_BUF_WIDTH-1:0] word_s;
  logic                     last_stb_s;
  logic                     chk_err_s;
  logic                     mem_we_s;
  logic [UOP_BUF_WIDTH-1:0] rd_word_s;

  logic [UOP_BUF_WIDTH-1:0] mem [0:UOP_BUF_SIZE-1];

  // A restart in the same cycle as a byte wins and the byte is dropped.
  assign xfer_s = ld_valid & ld_ready_q & ~ld_restart;

  uop_store_packer #(
    .WIDTH (UOP_BUF_WIDTH)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clr      (ld_restart),
    .byte_en  (xfer_s),
    .byte_in  (ld_byte),
    .last_in  (ld_last),
    .word_stb (word_stb_s),
    .word_out (word_s),
    .last_stb (last_stb_s),
    .chk_err  (chk_err_s)
  );

  assign rd_word_s = mem[uop_addr];

  // Load FSM, write pointer, committed length and fetch gating.
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    loaded_d    = loaded_q;
    ld_err_d    = ld_err_q;
    chk_bad_d   = chk_bad_q;
    uop_d       = '0;
    uop_valid_d = 1'b0;
    mem_we_s    = 1'b0;
    if (ld_restart) begin
      state_d   = LOAD;
      waddr_d   = '0;
      loaded_d  = '0;
      ld_err_d  = 1'b0;
      chk_bad_d = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (word_stb_s) begin
            // A word past the end of the RAM is dropped so the loader can still drain.
            if (waddr_q == SIZE_C) begin
              ld_err_d = 1'b1;
            end else begin
              mem_we_s = 1'b1;
              waddr_d  = waddr_q + ONE_C;
            end
          end else begin
            waddr_d = waddr_q;
          end
          if (last_stb_s) begin
            state_d  = RUN;
            loaded_d = waddr_d;
            if (chk_err_s) begin
              ld_err_d  = 1'b1;
              chk_bad_d = 1'b1;
            end else begin
              chk_bad_d = chk_bad_q;
            end
          end else begin
            state_d = LOAD;
          end
        end
        RUN: begin
          if ((CW'(uop_addr) < loaded_q) && !chk_bad_q) begin
            uop_d       = rd_word_s;
            uop_valid_d = 1'b1;
          end else begin
            uop_d       = '0;
            uop_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = LOAD;
        end
      endcase
    end
    ld_ready_d = (state_d == LOAD);
    ld_done_d  = (state_d == RUN);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD;
      waddr_q     <= '0;
      loaded_q    <= '0;
      uop_q       <= '0;
      uop_valid_q <= 1'b0;
      ld_ready_q  <= 1'b0;
      ld_done_q   <= 1'b0;
      ld_err_q    <= 1'b0;
      chk_bad_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      loaded_q    <= loaded_d;
      uop_q       <= uop_d;
      uop_valid_q <= uop_valid_d;
      ld_ready_q  <= ld_ready_d;
      ld_done_q   <= ld_done_d;
      ld_err_q    <= ld_err_d;
      chk_bad_q   <= chk_bad_d;
    end
  end

  // uop RAM; contents survive reset and are hidden by the committed length.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[waddr_q[AW-1:0]] <= word_s;
    end
  end

  assign uop       = uop_q;
  assign uop_valid = uop_valid_q;
  assign ld_ready  = ld_ready_q;
  assign ld_done   = ld_done_q;
  assign ld_err    = ld_err_q;

endmodule

// File: tb/tb_uop_store.sv
// Directed bench for uop_store: a default-size instance and a 4-entry instance
// share one stimulus stream so overflow can be observed alongside normal loads.
module tb_uop_store;

  logic        clk;
  logic        rst_n;
  logic [6:0]  uop_addr;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_restart;

  logic [31:0] uop_b, uop_s;
  logic        uop_valid_b, uop_valid_s;
  logic        ld_ready_b, ld_ready_s;
  logic        ld_done_b, ld_done_s;
  logic        ld_err_b, ld_err_s;

  int errors;
  int checks;
  logic [7:0] img [$];

  uop_store dut (
    .clk        (clk),
    .reset      (rst_n),
    .uop_addr   (uop_addr),
    .uop        (uop_b),
    .uop_valid  (uop_valid_b),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready_b),
    .ld_byte    (ld_byte),
    .ld_last    (ld_last),
    .ld_restart (ld_restart),
    .ld_done    (ld_done_b),
    .ld_err     (ld_err_b)
  );

  uop_store #(.UOP_BUF_SIZE(4), .UOP_BUF_WIDTH(32)) dut_small (
    .clk        (clk),
    .reset      (rst_n),
    .uop_addr   (uop_addr[1:0]),
    .uop        (uop_s),
    .uop_valid  (uop_valid_s),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready_s),
    .ld_byte    (ld_byte),
    .ld_last    (ld_last),
    .ld_restart (ld_restart),
    .ld_done    (ld_done_s),
    .ld_err     (ld_err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic last);
    checks++;
    if (ld_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: ld_ready=%b expected 1", ld_ready_b);
    end
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Sends img as data; with the checksum build a trailer XOR byte closes the image.
  task automatic send_image();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < img.size(); i++) begin
      x = x ^ img[i];
`ifdef UOP_STORE_CHECKSUM_EN
      send_byte(img[i], 1'b0);
`else
      send_byte(img[i], (i == img.size() - 1));
`endif
    end
`ifdef UOP_STORE_CHECKSUM_EN
    send_byte(x, 1'b1);
`endif
  endtask

  task automatic pulse_restart();
    ld_restart = 1'b1;
    @(posedge clk);
    #1;
    ld_restart = 1'b0;
  endtask

  task automatic fetch(input logic [6:0] a);
    uop_addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({uop_b, uop_valid_b, ld_ready_b, ld_done_b, ld_err_b} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs: uop=%h v=%b rdy=%b done=%b err=%b expected all 0",
               uop_b, uop_valid_b, ld_ready_b, ld_done_b, ld_err_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ld_ready_b !== 1'b1 || ld_done_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b done=%b expected 1 0", ld_ready_b, ld_done_b);
    end
  endtask

  task automatic test_nominal();
    img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_byte(8'h78, 1'b0);
    checks++;
    if (uop_valid_b !== 1'b0 || uop_b !== 32'h0) begin
      errors++;
      $display("FAIL load_gating: uop=%h v=%b expected 0 0", uop_b, uop_valid_b);
    end
    img.delete(0);
    send_image();
    checks++;
    if (ld_done_b !== 1'b1 || ld_ready_b !== 1'b0) begin
      errors++;
      $display("FAIL nominal_done: done=%b rdy=%b expected 1 0", ld_done_b, ld_ready_b);
    end
    fetch(7'd0);
    checks++;
    if (uop_b !== 32'h12345678 || uop_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL nominal_w0: uop=%h v=%b expected 12345678 1", uop_b, uop_valid_b);
    end
    fetch(7'd1);
    checks++;
    if (uop_b !== 32'hDEADBEEF || uop_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL nominal_w1: uop=%h v=%b expected deadbeef 1", uop_b, uop_valid_b);
    end
  endtask

  task automatic test_partial();
    pulse_restart();
    checks++;
    if (ld_done_b !== 1'b0 || uop_valid_b !== 1'b0 || ld_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL restart_run: done=%b v=%b rdy=%b expected 0 0 1",
               ld_done_b, uop_valid_b, ld_ready_b);
    end
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB};
    send_image();
    fetch(7'd1);
    checks++;
    if (uop_b !== 32'h0000BBAA || uop_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL partial_w1: uop=%h v=%b expected 0000bbaa 1", uop_b, uop_valid_b);
    end
    fetch(7'd2);
    checks++;
    if (uop_b !== 32'h0 || uop_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL partial_beyond: uop=%h v=%b expected 0 0", uop_b, uop_valid_b);
    end
    fetch(7'd0);
    checks++;
    if (uop_b !== 32'h04030201 || uop_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL partial_w0: uop=%h v=%b expected 04030201 1", uop_b, uop_valid_b);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    logic [7:0]  x;
    logic        lst;
    pulse_restart();
    x = 8'h00;
    for (int i = 0; i < 5; i++) begin
      w = 32'h10203040 + 32'(i);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ld_ready_s !== 1'b1) begin
          errors++;
          $display("FAIL ovf_ready: word %0d byte %0d ld_ready=%b expected 1", i, k, ld_ready_s);
        end
`ifdef UOP_STORE_CHECKSUM_EN
        lst = 1'b0;
`else
        lst = (i == 4 && k == 3);
`endif
        x = x ^ w[8*k +: 8];
        send_byte(w[8*k +: 8], lst);
      end
    end
`ifdef UOP_STORE_CHECKSUM_EN
    checks++;
    if (ld_ready_s !== 1'b1 || ld_err_s !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain: rdy=%b err=%b expected 1 1", ld_ready_s, ld_err_s);
    end
    send_byte(x, 1'b1);
`endif
    checks++;
    if (ld_err_s !== 1'b1 || ld_done_s !== 1'b1 || ld_err_b !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flags: small err=%b done=%b big err=%b expected 1 1 0",
               ld_err_s, ld_done_s, ld_err_b);
    end
    for (int a = 0; a < 4; a++) begin
      fetch(7'(a));
      checks++;
      if (uop_s !== 32'h10203040 + 32'(a) || uop_valid_s !== 1'b1) begin
        errors++;
        $display("FAIL ovf_word: addr %0d uop=%h v=%b expected %h 1",
                 a, uop_s, uop_valid_s, 32'h10203040 + 32'(a));
      end
    end
    fetch(7'd4);
    checks++;
    if (uop_b !== 32'h10203044 || uop_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL ovf_big_w4: uop=%h v=%b expected 10203044 1", uop_b, uop_valid_b);
    end
  endtask

  task automatic test_restart();
    pulse_restart();
    checks++;
    if (ld_err_s !== 1'b0 || ld_done_s !== 1'b0 || uop_valid_b !== 1'b0 || uop_b !== 32'h0) begin
      errors++;
      $display("FAIL restart_clear: err=%b done=%b v=%b uop=%h expected 0 0 0 0",
               ld_err_s, ld_done_s, uop_valid_b, uop_b);
    end
    img = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    send_image();
    fetch(7'd0);
    checks++;
    if (uop_b !== 32'hCAFEF00D || uop_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL restart_w0: uop=%h v=%b expected cafef00d 1", uop_b, uop_valid_b);
    end
    fetch(7'd1);
    checks++;
    if (uop_b !== 32'h0 || uop_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL restart_stale: uop=%h v=%b expected 0 0", uop_b, uop_valid_b);
    end
  endtask

  task automatic test_async_reset();
    pulse_restart();
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({uop_b, uop_valid_b, ld_ready_b, ld_done_b, ld_err_b} !== 36'h0) begin
      errors++;
      $display("FAIL async_reset: uop=%h v=%b rdy=%b done=%b err=%b expected all 0",
               uop_b, uop_valid_b, ld_ready_b, ld_done_b, ld_err_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    img = '{8'h0D, 8'hF0, 8'hAD, 8'h0B};
    send_image();
    fetch(7'd0);
    checks++;
    if (uop_b !== 32'h0BADF00D || uop_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL async_reload: uop=%h v=%b expected 0badf00d 1", uop_b, uop_valid_b);
    end
    fetch(7'd1);
    checks++;
    if (uop_valid_b !== 1'b0 || uop_b !== 32'h0) begin
      errors++;
      $display("FAIL async_stale: uop=%h v=%b expected 0 0", uop_b, uop_valid_b);
    end
  endtask

  task automatic test_back_to_back();
    pulse_restart();
    send_byte(8'h99, 1'b0);
    send_byte(8'h98, 1'b0);
    ld_restart = 1'b1;
    ld_valid   = 1'b1;
    ld_byte    = 8'hEE;
    @(posedge clk);
    #1;
    ld_restart = 1'b0;
    ld_valid   = 1'b0;
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_image();
    fetch(7'd0);
    checks++;
    if (uop_b !== 32'h44332211 || uop_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL simul_w0: uop=%h v=%b expected 44332211 1", uop_b, uop_valid_b);
    end
    fetch(7'd1);
    checks++;
    if (uop_b !== 32'h88776655 || uop_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL simul_w1: uop=%h v=%b expected 88776655 1", uop_b, uop_valid_b);
    end
  endtask

`ifdef UOP_STORE_CHECKSUM_EN
  task automatic test_checksum();
    pulse_restart();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h44, 1'b1);
    checks++;
    if (ld_done_b !== 1'b1 || ld_err_b !== 1'b0) begin
      errors++;
      $display("FAIL csum_good_flags: done=%b err=%b expected 1 0", ld_done_b, ld_err_b);
    end
    fetch(7'd0);
    checks++;
    if (uop_b !== 32'h44332211 || uop_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL csum_good_w0: uop=%h v=%b expected 44332211 1", uop_b, uop_valid_b);
    end
    pulse_restart();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h45, 1'b1);
    fetch(7'd0);
    checks++;
    if (ld_err_b !== 1'b1 || ld_done_b !== 1'b1 || uop_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL csum_bad: err=%b done=%b v=%b expected 1 1 0",
               ld_err_b, ld_done_b, uop_valid_b);
    end
    pulse_restart();
    send_byte(8'h00, 1'b1);
    fetch(7'd0);
    checks++;
    if (ld_done_b !== 1'b1 || ld_err_b !== 1'b0 || uop_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL csum_empty: done=%b err=%b v=%b expected 1 0 0",
               ld_done_b, ld_err_b, uop_valid_b);
    end
  endtask
`else
  task automatic test_last_is_data();
    pulse_restart();
    send_byte(8'h5A, 1'b1);
    fetch(7'd0);
    checks++;
    if (uop_b !== 32'h0000005A || uop_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL single_byte_w0: uop=%h v=%b expected 0000005a 1", uop_b, uop_valid_b);
    end
    fetch(7'd1);
    checks++;
    if (uop_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL single_byte_w1: v=%b expected 0", uop_valid_b);
    end
  endtask
`endif

  initial begin
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    uop_addr   = 7'd0;
    ld_valid   = 1'b0;
    ld_byte    = 8'h00;
    ld_last    = 1'b0;
    ld_restart = 1'b0;
    test_reset();
    test_nominal();
    test_partial();
    test_overflow();
    test_restart();
    test_async_reset();
    test_back_to_back();
`ifdef UOP_STORE_CHECKSUM_EN
    test_checksum();
`else
    test_last_is_data();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uop_store.md
Name: uop_store

Overview:
Microcode store that answers the microcode sequencer's fetch interface. The sequencer drives uop_addr and this block returns uop.
- Before serving fetches, the store is filled through a byte-serial loader port with a valid/ready handshake.
- The block owns the uop RAM, the load FSM and fetch gating. The sequencer sees zero uops until loading completes.

Parameters:
- UOP_BUF_SIZE, 128, number of uop entries.
- UOP_BUF_WIDTH, 32, uop width in bits. Any value ≥ 8; bytes per uop BPU = ceil(UOP_BUF_WIDTH/8).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- uop_addr  in  $clog2(UOP_BUF_SIZE)  fetch address from the sequencer.
- uop  out  UOP_BUF_WIDTH  fetched uop, registered.
- uop_valid  out  1  uop holds a loaded entry.
- ld_valid  in  1  loader byte valid.
- ld_ready  out  1  store accepts a byte.
- ld_byte  in  8  loader data byte.
- ld_last  in  1  qualifies the final byte of the image.
- ld_restart  in  1  single-cycle pulse; returns the store to LOAD.
- ld_done  out  1  image committed; store is serving fetches.
- ld_err  out  1  sticky load error.

Behaviour:
- Reset (reset=0, asynchronous): state=LOAD, waddr=0, bcnt=0, loaded=0, uop=0, uop_valid=0, ld_ready=0, ld_done=0, ld_err=0. The RAM is not cleared.
- Byte transfer: a byte transfers on a rising edge with ld_valid & ld_ready. ld_ready=1 exactly while state=LOAD.
- LOAD, packing:
  - Bytes pack little-endian into a word buffer: byte k goes to bits [8k+7:8k], bits above UOP_BUF_WIDTH are discarded.
  - bcnt counts 0..BPU-1. On the BPU-th byte, the word is written to mem[waddr], then waddr++ and bcnt=0.
- LOAD, last byte (ld_last transfers):
  - A partially filled word is zero-padded and written.
  - loaded = number of words written.
  - State goes to RUN and ld_done=1 on the next cycle.
  - ld_last with bcnt=0 after a complete word writes nothing extra.
- Overflow: if a word completes when waddr==UOP_BUF_SIZE, ld_err=1 (sticky) and the word is dropped. ld_ready stays 1, so the loader drains up to ld_last without deadlock. loaded saturates at UOP_BUF_SIZE.
- Empty image: ld_last on the very first byte with BPU>1 writes one padded word, so loaded=1.
- RUN, fetch:
  - 1-cycle latency: uop(t+1) = mem[uop_addr(t)] if uop_addr(t) < loaded, else 0.
  - uop_valid(t+1) = (uop_addr(t) < loaded).
  - Addresses ≥ UOP_BUF_SIZE (non-power-of-2 size) read 0 with uop_valid=0.
- During LOAD: uop=0, uop_valid=0 every cycle.
- ld_restart:
  - In RUN: state=LOAD next cycle; waddr, bcnt, loaded, ld_done and ld_err clear; uop and uop_valid drop to 0 on the same edge.
  - In LOAD: the same clear. A byte transferring in that same cycle is discarded, and ld_restart wins.
- Asynchronous reset mid-load: the partial image is abandoned and loaded=0. Stale RAM contents are never visible because loaded gates reads.

Optional Feature:
- Macro UOP_STORE_CHECKSUM_EN.
- With the macro:
  - The byte carrying ld_last is a checksum, not data, and is never written.
  - The running XOR of all preceding data bytes is compared with it. On mismatch, ld_err=1; still go to RUN with uop_valid forced 0 for all addresses until restart.
  - An image consisting of only ld_last gives loaded=0.
- Without the macro: the ld_last byte is data, as described above.

Decomposition:
- Package uop_store_pkg:
  - state enum uop_store_state_e {LOAD, RUN}.
  - function bytes_per_uop(width).
  - localparam for the byte width (8).
- One sub-module, uop_store_packer: byte to word assembly, holding bcnt, the word buffer, zero-padding and the checksum XOR. It emits a word strobe plus a last flag.
- The top level holds the FSM, waddr/loaded counters, RAM and the fetch register.

Test Plan:
- Nominal load: defaults, 8 bytes 78 56 34 12 EF BE AD DE with ld_last on the 8th; then uop_addr=0, then 1.
  - uop=32'h12345678 and 32'hDEADBEEF, each 1 cycle after its address; uop_valid=1; ld_done=1.
- Partial word: 6 bytes 01 02 03 04 AA BB (last).
  - mem[1] reads 32'h0000BBAA.
  - uop_addr=2 returns 0 with uop_valid=0.
- Overflow: UOP_BUF_SIZE=4; 5 words + last.
  - ld_err=1; ld_ready stays 1 through ld_last.
  - Addresses 0..3 hold words 0..3; word 4 is absent.
- Restart and reset mid-load:
  - ld_restart in RUN, then a 1-word image 0xCAFEF00D: loaded=1, addr 1 returns 0.
  - Async reset low after 2 bytes: all outputs 0 immediately, no clock needed.
- Simultaneous: ld_restart together with a valid byte in the same cycle; the byte is discarded and the next image starts at word 0.
- Checksum (UOP_STORE_CHECKSUM_EN):
  - Bytes 11 22 33 44 then last=0x44: RUN, uop=32'h44332211.
  - Last=0x45 instead: ld_err=1 and uop_valid=0.
